rsa_seq_ctrl: RTL and testbench
===============================

// Module: rsa_seq_ctrl
// PURPOSE
//  Parametrised sequencer between the start/stop command sources (GPIO, SPI, ...) and rsa_unit.
//  On start: holds rsa_unit in reset for a programmable time, then enables it, and waits for its end-of-conversion.
//  Reports completion as a level and a pulse. Also provides stop/abort, a watchdog timeout, a busy flag and sticky error flags.
// PARAMETERS
//  N_SRC      2   number of command sources; bit 0 = GPIO, bit 1 = SPI
//  RST_CYC    2   cycles rst_rsa is held low before en_rsa rises (>=1)
//  TO_W       16  width of the timeout counter and the timeout_cyc input
//  STOP_AND   1   1: abort only when all stop_req bits are high; 0: abort when any bit is high
// PORTS
//  clk          in   1      system clock
//  rstb         in   1      asynchronous active-low reset
//  ena          in   1      global enable; when 0, all state and counters freeze
//  start_req    in   N_SRC  start requests, ORed together
//  stop_req     in   N_SRC  stop requests, combined per STOP_AND
//  timeout_cyc  in   TO_W   RUN-state watchdog limit; 0 disables the watchdog
//  eoc_rsa_unit in   1      end of conversion from rsa_unit, level
//  en_rsa       out  1      enable to rsa_unit
//  rst_rsa      out  1      active-low reset to rsa_unit
//  busy         out  1      high in RESET, RUN and DONE_P
//  eoc          out  1      completion level; held until the next start
//  eoc_pulse    out  1      one-cycle completion strobe
//  err_timeout  out  1      sticky; cleared by the next accepted start
//  err_abort    out  1      sticky; cleared by the next accepted start
// BEHAVIOUR
//  Reset (rstb=0, async): state=IDLE, counters=0.
//   Outputs: en_rsa=0, rst_rsa=0, busy=0, eoc=0, eoc_pulse=0, err_*=0.
//  All outputs are registered. Every register advances only when ena=1; with ena=0 all outputs hold.
//  start = |start_req. stop = STOP_AND ? &stop_req : |stop_req.
//  FSM states: IDLE, RESET, RUN, DONE_P, DONE.
//  IDLE/DONE:
//   - start=1 -> go to RESET. Clear eoc and err_*, set cnt=0, rst_rsa=0, en_rsa=1, busy=1.
//   - When start and stop are high together in IDLE/DONE, start wins.
//  RESET:
//   - cnt increments each cycle.
//   - When cnt==RST_CYC-1 -> go to RUN, rst_rsa=1, cnt=0.
//   - rst_rsa is therefore low for exactly RST_CYC enabled cycles.
//  RUN:
//   - eoc_rsa_unit=1 -> go to DONE_P, eoc_pulse=1, eoc=1.
//   - Else stop=1 -> abort.
//   - Else timeout_cyc!=0 and cnt==timeout_cyc-1 -> abort with err_timeout=1.
//   - Else cnt++. cnt saturates at all-ones.
//   - If eoc_rsa_unit and stop are high in the same cycle, completion wins.
//  DONE_P: go to DONE, eoc_pulse=0, busy=0, en_rsa=0. rst_rsa stays 1 so the rsa_unit result is preserved.
//  abort, from RESET or RUN:
//   - Go to IDLE with en_rsa=0, rst_rsa=0, busy=0, eoc=0.
//   - err_abort=1 when the cause is stop; err_timeout=1 when the cause is the watchdog.
//  start while busy: ignored; no restart.
//  stop in RESET: aborts the same as in RUN.
//  stop in DONE_P/DONE: ignored.
//  Latencies, counted from the start cycle:
//   - rst_rsa rises RST_CYC+1 cycles later.
//   - eoc_pulse rises 1 cycle after eoc_rsa_unit is sampled high in RUN.
//  Reset asserted mid-operation: immediate return to IDLE with reset values.
// STRUCTURE
//  Package rsa_pkg: typedef enum logic [2:0] rsa_seq_state_t {IDLE,RESET,RUN,DONE_P,DONE}; localparam SRC_GPIO=0, SRC_SPI=1.
//  Sub-module rsa_req_combine: parametrised start-OR / stop-AND-or-OR reduction, purely combinational.
//  The FSM and the shared TO_W-bit counter stay in this module.
// TESTING
//  1. Defaults, ena=1, pulse start_req=01; eoc_rsa_unit rises 5 cycles after rst_rsa rises
//     -> rst_rsa low 2 cycles, en_rsa=1, eoc_pulse 1 cycle, eoc=1 held, busy low after DONE_P.
//  2. timeout_cyc=4, eoc_rsa_unit never asserted -> 4 RUN cycles, then IDLE, err_timeout=1, en_rsa=0, rst_rsa=0.
//  3. STOP_AND=1: stop_req=01 in RUN -> no abort. stop_req=11 -> IDLE next cycle, err_abort=1.
//  4. ena=0 for 3 cycles mid-RESET -> all outputs frozen. rst_rsa low for exactly RST_CYC enabled cycles in total.
//  5. eoc_rsa_unit and stop high in the same RUN cycle -> DONE_P, eoc=1, err_abort=0.
//     A new start from DONE clears eoc.
//  6. rstb pulsed low during RUN -> all outputs return to reset values asynchronously.
//     A start_req=10 after release runs a full sequence.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types and constants for the rsa_unit start/stop sequencer.
package rsa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    RUN,
    DONE_P,
    DONE
  } rsa_seq_state_t;

  // Bit positions of the command sources within start_req/stop_req.
  localparam int unsigned SRC_GPIO = 0;
  localparam int unsigned SRC_SPI  = 1;

endpackage

// File: rtl/rsa_req_combine.sv
// Reduces the per-source start/stop request vectors to single start/stop commands.
module rsa_req_combine
  import rsa_pkg::*;
#(
  parameter int unsigned N_SRC    = 2,
  parameter bit          STOP_AND = 1'b1
) (
  input  logic [N_SRC-1:0] start_req,
  input  logic [N_SRC-1:0] stop_req,
  output logic             start,
  output logic             stop
);

  // Any source may start; stop needs either unanimous or any-source agreement.
  always_comb begin
    start = |start_req;
    stop  = STOP_AND ? (&stop_req) : (|stop_req);
  end

endmodule

// File: rtl/rsa_seq_ctrl.sv
// Sequencer for rsa_unit: timed reset, enable, completion reporting, abort and watchdog.
module rsa_seq_ctrl
  import rsa_pkg::*;
#(
  parameter int unsigned N_SRC    = 2,
  parameter int unsigned RST_CYC  = 2,
  parameter int unsigned TO_W     = 16,
  parameter bit          STOP_AND = 1'b1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic [N_SRC-1:0] start_req,
  input  logic [N_SRC-1:0] stop_req,
  input  logic [TO_W-1:0]  timeout_cyc,
  input  logic             eoc_rsa_unit,
  output logic             en_rsa,
  output logic             rst_rsa,
  output logic             busy,
  output logic             eoc,
  output logic             eoc_pulse,
  output logic             err_timeout,
  output logic             err_abort
);

  localparam logic [TO_W-1:0] RST_LAST = TO_W'(RST_CYC - 1);
  localparam logic [TO_W-1:0] CNT_MAX  = '1;
  localparam logic [TO_W-1:0] CNT_ONE  = TO_W'(1);

  logic start, stop;

  rsa_req_combine #(
    .N_SRC    (N_SRC),
    .STOP_AND (STOP_AND)
  ) u_req_combine (
    .start_req (start_req),
    .stop_req  (stop_req),
    .start     (start),
    .stop      (stop)
  );

  rsa_seq_state_t  state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            en_rsa_q, en_rsa_d;
  logic            rst_rsa_q, rst_rsa_d;
  logic            busy_q, busy_d;
  logic            eoc_q, eoc_d;
  logic            eoc_pulse_q, eoc_pulse_d;
  logic            err_timeout_q, err_timeout_d;
  logic            err_abort_q, err_abort_d;
  logic            abort_stop, abort_to;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    en_rsa_d      = en_rsa_q;
    rst_rsa_d     = rst_rsa_q;
    busy_d        = busy_q;
    eoc_d         = eoc_q;
    eoc_pulse_d   = eoc_pulse_q;
    err_timeout_d = err_timeout_q;
    err_abort_d   = err_abort_q;
    abort_stop    = 1'b0;
    abort_to      = 1'b0;

    if (ena) begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d       = RESET;
            cnt_d         = '0;
            rst_rsa_d     = 1'b0;
            en_rsa_d      = 1'b1;
            busy_d        = 1'b1;
            eoc_d         = 1'b0;
            err_timeout_d = 1'b0;
            err_abort_d   = 1'b0;
          end
        end
        RESET: begin
          if (stop) begin
            abort_stop = 1'b1;
          end else if (cnt_q == RST_LAST) begin
            state_d   = RUN;
            rst_rsa_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        RUN: begin
          // Completion outranks stop, which outranks the watchdog.
          if (eoc_rsa_unit) begin
            state_d     = DONE_P;
            eoc_pulse_d = 1'b1;
            eoc_d       = 1'b1;
          end else if (stop) begin
            abort_stop = 1'b1;
          end else if ((timeout_cyc != '0) && (cnt_q == timeout_cyc - CNT_ONE)) begin
            abort_to = 1'b1;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        DONE_P: begin
          // rst_rsa stays high so rsa_unit keeps its result.
          state_d     = DONE;
          eoc_pulse_d = 1'b0;
          busy_d      = 1'b0;
          en_rsa_d    = 1'b0;
        end
        default: state_d = IDLE;
      endcase

      if (abort_stop || abort_to) begin
        state_d   = IDLE;
        en_rsa_d  = 1'b0;
        rst_rsa_d = 1'b0;
        busy_d    = 1'b0;
        eoc_d     = 1'b0;
        cnt_d     = '0;
        if (abort_stop) err_abort_d   = 1'b1;
        if (abort_to)   err_timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      en_rsa_q      <= 1'b0;
      rst_rsa_q     <= 1'b0;
      busy_q        <= 1'b0;
      eoc_q         <= 1'b0;
      eoc_pulse_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      err_abort_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      en_rsa_q      <= en_rsa_d;
      rst_rsa_q     <= rst_rsa_d;
      busy_q        <= busy_d;
      eoc_q         <= eoc_d;
      eoc_pulse_q   <= eoc_pulse_d;
      err_timeout_q <= err_timeout_d;
      err_abort_q   <= err_abort_d;
    end
  end

  assign en_rsa      = en_rsa_q;
  assign rst_rsa     = rst_rsa_q;
  assign busy        = busy_q;
  assign eoc         = eoc_q;
  assign eoc_pulse   = eoc_pulse_q;
  assign err_timeout = err_timeout_q;
  assign err_abort   = err_abort_q;

endmodule

// File: tb/tb_rsa_seq_ctrl.sv
// Bench for rsa_seq_ctrl: directed scenarios plus random traffic against a phase-level model.
module tb_rsa_seq_ctrl;

  localparam int unsigned N_SRC   = 2;
  localparam int unsigned RST_CYC = 2;
  localparam int unsigned TO_W    = 16;

  localparam int P_IDLE = 0, P_RESET = 1, P_RUN = 2, P_DONEP = 3, P_DONE = 4;

  logic             clk = 1'b0;
  logic             rstb;
  logic             ena;
  logic [N_SRC-1:0] start_req;
  logic [N_SRC-1:0] stop_req;
  logic [TO_W-1:0]  timeout_cyc;
  logic             eoc_rsa_unit;
  logic             en_rsa, rst_rsa, busy, eoc, eoc_pulse, err_timeout, err_abort;

  int n_checks = 0;
  int n_errors = 0;

  // Model: which phase we are in, how many enabled cycles spent in it, sticky errors.
  int phase;
  int n_in_phase;
  bit m_err_to, m_err_ab;

  rsa_seq_ctrl #(
    .N_SRC    (N_SRC),
    .RST_CYC  (RST_CYC),
    .TO_W     (TO_W),
    .STOP_AND (1'b1)
  ) dut (
    .clk          (clk),
    .rstb         (rstb),
    .ena          (ena),
    .start_req    (start_req),
    .stop_req     (stop_req),
    .timeout_cyc  (timeout_cyc),
    .eoc_rsa_unit (eoc_rsa_unit),
    .en_rsa       (en_rsa),
    .rst_rsa      (rst_rsa),
    .busy         (busy),
    .eoc          (eoc),
    .eoc_pulse    (eoc_pulse),
    .err_timeout  (err_timeout),
    .err_abort    (err_abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {25'd0, err_abort, err_timeout, eoc_pulse, eoc, busy, rst_rsa, en_rsa};
  endfunction

  // Outputs follow directly from the phase the sequence is in.
  function automatic logic [31:0] model_vec();
    bit active = (phase == P_RESET) || (phase == P_RUN) || (phase == P_DONEP);
    bit out_of_reset = (phase == P_RUN) || (phase == P_DONEP) || (phase == P_DONE);
    bit done = (phase == P_DONEP) || (phase == P_DONE);
    return {25'd0, m_err_ab, m_err_to, (phase == P_DONEP), done, active, out_of_reset, active};
  endfunction

  function automatic void model_reset();
    phase = P_IDLE; n_in_phase = 0; m_err_to = 0; m_err_ab = 0;
  endfunction

  function automatic void model_step();
    bit st = |start_req;
    bit sp = &stop_req;
    if (!rstb) begin model_reset(); return; end
    if (!ena) return;
    case (phase)
      P_IDLE, P_DONE:
        if (st) begin phase = P_RESET; n_in_phase = 0; m_err_to = 0; m_err_ab = 0; end
      P_RESET:
        if (sp) begin phase = P_IDLE; m_err_ab = 1; end
        else begin
          n_in_phase++;
          if (n_in_phase == int'(RST_CYC)) begin phase = P_RUN; n_in_phase = 0; end
        end
      P_RUN:
        if (eoc_rsa_unit) phase = P_DONEP;
        else if (sp) begin phase = P_IDLE; m_err_ab = 1; end
        else begin
          n_in_phase++;
          if (timeout_cyc != 0 && n_in_phase == int'(timeout_cyc)) begin
            phase = P_IDLE; m_err_to = 1;
          end
        end
      P_DONEP: phase = P_DONE;
      default: phase = P_IDLE;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("outputs", dut_vec(), model_vec());
  endtask

  task automatic pulse_reset();
    rstb = 1'b0;
    #1;
    model_reset();
    check("async_reset", dut_vec(), 32'd0);
    step();
    step();
    #3 rstb = 1'b1;
  endtask

  task automatic start_and_reach_run(input logic [N_SRC-1:0] src);
    bit reached = 0;
    start_req = src;
    step();
    start_req = '0;
    for (int i = 0; i < 20; i++) begin
      if (rst_rsa && busy) begin reached = 1; break; end
      step();
    end
    check("reach_run", 32'(reached), 32'd1);
  endtask

  initial begin
    int low_cnt, pulse_cnt, run_cnt;
    rstb = 1'b0; ena = 1'b1; start_req = '0; stop_req = '0;
    timeout_cyc = '0; eoc_rsa_unit = 1'b0;
    model_reset();
    #12;
    check("reset_state", dut_vec(), 32'd0);
    rstb = 1'b1;
    step();

    // 1: full sequence from GPIO
    start_req = 2'b01;
    step();
    start_req = '0;
    low_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (rst_rsa) break;
      check("en_during_reset", 32'(en_rsa), 32'd1);
      low_cnt++;
      step();
    end
    check("rst_low_cycles", low_cnt, RST_CYC);
    repeat (4) step();
    eoc_rsa_unit = 1'b1;
    step();
    check("eoc_pulse_rise", 32'(eoc_pulse), 32'd1);
    pulse_cnt = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (eoc_pulse) pulse_cnt++;
    end
    check("eoc_pulse_width", pulse_cnt, 1);
    check("eoc_held", 32'(eoc), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
    eoc_rsa_unit = 1'b0;

    // 2: watchdog
    timeout_cyc = 16'd4;
    start_and_reach_run(2'b01);
    run_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (!(rst_rsa && busy)) break;
      run_cnt++;
      step();
    end
    check("run_cycles_to_timeout", run_cnt, 4);
    check("err_timeout", 32'(err_timeout), 32'd1);
    check("timeout_en_rst", {30'd0, en_rsa, rst_rsa}, 32'd0);
    timeout_cyc = '0;

    // 3: stop needs all sources
    start_and_reach_run(2'b10);
    check("err_timeout_cleared", 32'(err_timeout), 32'd0);
    stop_req = 2'b01;
    repeat (3) step();
    check("partial_stop_busy", 32'(busy), 32'd1);
    stop_req = 2'b11;
    step();
    stop_req = '0;
    check("stop_abort", {30'd0, busy, err_abort}, 32'd1);

    // 4: ena freeze mid-RESET
    start_req = 2'b01;
    step();
    start_req = '0;
    low_cnt = rst_rsa ? 0 : 1;
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frozen", {30'd0, busy, rst_rsa}, 32'd2);
    end
    ena = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (rst_rsa) break;
      low_cnt++;
    end
    check("rst_low_enabled", low_cnt, RST_CYC);

    // 5: completion beats stop; restart clears eoc
    eoc_rsa_unit = 1'b1; stop_req = 2'b11;
    step();
    eoc_rsa_unit = 1'b0; stop_req = '0;
    check("eoc_vs_stop", {29'd0, eoc, eoc_pulse, err_abort}, 32'd6);
    step();
    start_req = 2'b01;
    step();
    start_req = '0;
    check("restart_clears_eoc", 32'(eoc), 32'd0);

    // 6: async reset during RUN, then SPI-driven sequence
    for (int i = 0; i < 5; i++) step();
    pulse_reset();
    start_and_reach_run(2'b10);
    repeat (2) step();
    eoc_rsa_unit = 1'b1;
    step();
    eoc_rsa_unit = 1'b0;
    step();
    check("after_reset_seq_eoc", 32'(eoc), 32'd1);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      ena          = ($urandom_range(0, 9) != 0);
      start_req    = ($urandom_range(0, 6) == 0) ? N_SRC'($urandom) : '0;
      stop_req     = ($urandom_range(0, 14) == 0) ? 2'b11 : N_SRC'($urandom_range(0, 1));
      eoc_rsa_unit = ($urandom_range(0, 11) == 0);
      if (c % 60 == 0) begin
        case ($urandom_range(0, 3))
          0: timeout_cyc = 16'd0;
          1: timeout_cyc = 16'd1;
          2: timeout_cyc = 16'd5;
          default: timeout_cyc = 16'd15;
        endcase
      end
      if ($urandom_range(0, 149) == 0) pulse_reset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
